// File: rtl/leaf_config_sender.sv
// Transmitting end of the leaf configuration protocol: queues host commands in a
// small FIFO and serialises them as BFT packets, honouring resend with bounded retries.
module leaf_config_sender #(
  parameter int PACKET_BITS   = 49,
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 5,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_ADDR_BITS = 7,
  parameter int FIFO_DEPTH    = 4,
  parameter int MAX_RETRY     = 15,
  parameter int COUNT_BITS    = 16
) (
  input  logic                     clk_bft,
  input  logic                     reset,
  input  logic                     cmd_vld,
  output logic                     cmd_ack,
  input  logic [NUM_LEAF_BITS-1:0] cmd_leaf,
  input  logic                     cmd_port,
  input  logic [NUM_ADDR_BITS-1:0] cmd_addr,
  input  logic [PAYLOAD_BITS-1:0]  cmd_data,
  output logic [PACKET_BITS-1:0]   dout_leaf_config2bft,
  input  logic                     resend,
  output logic                     busy,
  output logic                     retry_err,
  output logic [COUNT_BITS-1:0]    sent_cnt,
  output logic                     dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = PACKET_BITS - 1;

  typedef enum logic {IDLE, SEND} state_t;

  // Handshake: a command transfers on a rising edge where cmd_vld && cmd_ack;
  // the bus packet is consumed on an edge where it is valid and resend is low.
  logic [CW-1:0]         mem_q [FIFO_DEPTH];
  logic [AW:0]           wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
  logic                  empty, full, push, pop;
  logic [CW-1:0]         head;
  state_t                state_q, state_d;
  logic [PACKET_BITS-1:0] out_q, out_d;
  logic [7:0]            retry_q, retry_d;
  logic [COUNT_BITS-1:0] sent_q, sent_d;
  logic                  err_q, err_d;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign cmd_ack = !full;
  assign push    = cmd_vld && !full;
  assign head    = mem_q[rd_ptr_q[AW-1:0]];
  assign wr_ptr_d = wr_ptr_q + (AW+1)'(push);
  assign rd_ptr_d = rd_ptr_q + (AW+1)'(pop);

  always_ff @(posedge clk_bft) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {cmd_leaf, {(NUM_PORT_BITS-1){1'b0}}, cmd_port, cmd_addr, cmd_data};
    end
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    retry_d = retry_q;
    sent_d  = sent_q;
    err_d   = err_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        out_d   = '0;
        retry_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          out_d   = {1'b1, head};
          state_d = SEND;
        end
      end
      default: begin
        if (resend && (retry_q < 8'(MAX_RETRY))) begin
          retry_d = retry_q + 8'd1;
        end else begin
          // Either accepted or dropped after the retry budget: move on.
          if (resend) err_d = 1'b1;
          else        sent_d = sent_q + COUNT_BITS'(1);
          retry_d = '0;
          if (!empty) begin
            pop   = 1'b1;
            out_d = {1'b1, head};
          end else begin
            out_d   = '0;
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_bft or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      state_q  <= IDLE;
      out_q    <= '0;
      retry_q  <= '0;
      sent_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      state_q  <= state_d;
      out_q    <= out_d;
      retry_q  <= retry_d;
      sent_q   <= sent_d;
      err_q    <= err_d;
    end
  end

  assign dout_leaf_config2bft = out_q;
  assign busy                 = !empty || (state_q == SEND);
  assign retry_err            = err_q;
  assign sent_cnt             = sent_q;
  assign dbg_state            = (state_q == SEND);

endmodule

// File: doc/leaf_config_sender.md
# leaf_config_sender

Injects configuration packets into the BFT on behalf of a host/controller. It is the transmitting end of the leaf configuration protocol: it builds port-0/port-1 packets that a leaf's configuration path decodes into its control registers. It sits on the network side of a leaf port, driving the packet bus and honouring the network's `resend` back-pressure. Commands are buffered in a small FIFO and serialised onto the bus at up to one packet per cycle, with bounded retries.

## Interface

- `PACKET_BITS`, 49: packet width. Must equal 1+`NUM_LEAF_BITS`+`NUM_PORT_BITS`+`NUM_ADDR_BITS`+`PAYLOAD_BITS`.
- `PAYLOAD_BITS`, 32: payload field width.
- `NUM_LEAF_BITS`, 5: destination leaf field width.
- `NUM_PORT_BITS`, 4: destination port field width.
- `NUM_ADDR_BITS`, 7: register index field width.
- `FIFO_DEPTH`, 4: command FIFO depth; must be a power of 2 and at least 2.
- `MAX_RETRY`, 15: maximum consecutive resends of one packet before it is dropped; range 1..255.
- `COUNT_BITS`, 16: width of `sent_cnt`.

Ports:

- `clk_bft` in 1: the single clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `cmd_vld` in 1: command valid.
- `cmd_ack` out 1: command accepted when `cmd_vld`&`cmd_ack` at a rising edge.
- `cmd_leaf` in `NUM_LEAF_BITS`: destination leaf.
- `cmd_port` in 1: configuration port, 0 or 1.
- `cmd_addr` in `NUM_ADDR_BITS`: register index.
- `cmd_data` in `PAYLOAD_BITS`: register value.
- `dout_leaf_config2bft` out `PACKET_BITS`: packet to the BFT.
- `resend` in 1: the network rejected the packet currently on `dout_leaf_config2bft`.
- `busy` out 1: the FIFO is non-empty or the state is SEND.
- `retry_err` out 1: sticky flag; set when a packet is dropped after exceeding `MAX_RETRY`.
- `sent_cnt` out `COUNT_BITS`: number of packets accepted by the network.

## Operation

- **Packet format**, MSB to LSB:
  - valid bit = 1;
  - leaf field = `cmd_leaf`;
  - port field = `cmd_port` zero-extended to `NUM_PORT_BITS`;
  - address field = `cmd_addr`;
  - payload = `cmd_data`.
- **Idle bus:** when no packet is driven, `dout_leaf_config2bft` is all zeros (valid bit 0).
- **FIFO:**
  - Registered storage with read and write pointers of log2(`FIFO_DEPTH`)+1 bits; full and empty are decoded from the pointer MSB and remaining bits.
  - `cmd_ack` = !full, decoded from registered pointers only. A pop in the same cycle does not raise `cmd_ack`.
- **State machine, two states:**
  - **IDLE:**
    - Output register is zero and `retry_cnt` = 0.
    - If the FIFO is non-empty: pop the head into the output register (valid = 1) and go to SEND.
  - **SEND:** the output register is driven on the bus.
    - `resend`=1 and `retry_cnt` < `MAX_RETRY`: hold the packet unchanged and increment `retry_cnt`.
    - `resend`=1 and `retry_cnt` == `MAX_RETRY`: drop the packet, set `retry_err`, clear `retry_cnt`, then load the next FIFO head if any, otherwise go to IDLE.
    - `resend`=0: the packet is accepted. Increment `sent_cnt` (wraps modulo 2^`COUNT_BITS`) and clear `retry_cnt`. If the FIFO is non-empty, pop and load the next packet back-to-back and stay in SEND; otherwise clear the output register and go to IDLE.
- **Simultaneous push and pop:** allowed whenever the FIFO is not full. The occupancy is unchanged.
- **`retry_err`:** cleared only by `reset`.

## Timing

- Reset values: `dout_leaf_config2bft`=0, `cmd_ack`=1, `busy`=0, `retry_err`=0, `sent_cnt`=0, state IDLE, FIFO empty.
- Reset asserted mid-operation discards all queued and in-flight packets immediately (asynchronously). The bus is zero from the reset assertion onward.
- Latency: a command accepted at edge E, with the FIFO empty and the state IDLE, appears on the bus after edge E+1 (one cycle in the FIFO).
- Throughput: one packet per cycle while `resend`=0 and the FIFO is non-empty.
- `resend` is sampled at the edge closing a cycle in which a valid packet is driven. `resend` is ignored in IDLE.
- `sent_cnt` and `retry_err` update at the same edge that decides acceptance or drop.

## Test plan

- **Single write:** after reset, one command (leaf=3, port=1, addr=5, data=0xDEADBEEF) -> bus equals {1, 5'd3, 4'd1, 7'd5, 32'hDEADBEEF} for exactly one cycle starting two edges after the handshake, then zero; `sent_cnt`=1.
- **Back-to-back burst:** four commands on consecutive cycles with `resend`=0 -> four consecutive valid packets in order with no gaps; `cmd_ack` is never low with `FIFO_DEPTH`=4; `busy` falls one cycle after the last packet.
- **Back-pressure:** hold `resend`=1 for 3 cycles on the first packet -> the packet repeats 4 cycles unchanged, `sent_cnt` increments only once, and the queued second packet follows immediately.
- **Retry exhaustion:** `MAX_RETRY`=2, `resend` held high -> the packet is driven 3 cycles, then dropped; `retry_err`=1; `sent_cnt` is unchanged; the next queued packet starts on the following cycle.
- **Full FIFO:** hold `resend`=1 and push 5 commands -> `cmd_ack` goes low after 4 queued commands (plus 1 in SEND); the 6th command is held off until an acceptance frees a slot.
- **Reset mid-burst:** assert `reset` with 3 packets queued -> bus is 0 immediately; `busy`=0, `cmd_ack`=1, `sent_cnt`=0; no queued packet appears after release.
